// File: rtl/clk_enable_ctrl.sv
// Idle-timeout clock-enable controller feeding a clock gate cell.
// Drains and shuts the gated clock off after an idle period, and re-enables it on activity.
module clk_enable_ctrl #(
  parameter int IDLE_CYCLES  = 8,
  parameter int DRAIN_CYCLES = 2,
  parameter int WAKE_CYCLES  = 2,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             activity,
  input  logic             force_on,
  output logic             clken,
  output logic             ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] sleep_cnt
);

  typedef enum logic [1:0] {
    ST_ON    = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OFF   = 2'd2,
    ST_WAKE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] IDLE_LAST  = CNT_W'(IDLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] sleep_cnt_q, sleep_cnt_d;
  logic             clken_q, clken_d;
  logic             ready_q, ready_d;
  logic             wake;

  assign wake = activity | force_on;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sleep_cnt_d = sleep_cnt_q;
    case (state_q)
      ST_ON: begin
        if (wake) begin
          cnt_d = '0;
        end else if (cnt_q == IDLE_LAST) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // Wake wins over the drain timeout on the same edge.
        if (wake) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else if (cnt_q == DRAIN_LAST) begin
          state_d = ST_OFF;
          cnt_d   = '0;
          if (sleep_cnt_q != '1) sleep_cnt_d = sleep_cnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_OFF: begin
        if (wake) begin
          state_d = ST_WAKE;
          cnt_d   = '0;
        end
      end
      ST_WAKE: begin
        if (cnt_q == WAKE_LAST) begin
          state_d = ST_ON;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_ON;
        cnt_d   = '0;
      end
    endcase
    // Outputs are registered copies of the next-state decode, so they only move on clk edges.
    clken_d = (state_d != ST_OFF);
    ready_d = (state_d == ST_ON);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_ON;
      cnt_q       <= '0;
      sleep_cnt_q <= '0;
      clken_q     <= 1'b1;
      ready_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sleep_cnt_q <= sleep_cnt_d;
      clken_q     <= clken_d;
      ready_q     <= ready_d;
    end
  end

  assign clken     = clken_q;
  assign ready     = ready_q;
  assign state     = state_q;
  assign sleep_cnt = sleep_cnt_q;

endmodule

// File: tb/tb_clk_enable_ctrl.sv
// Directed bench: default instance for force_on hold, small instance
// (IDLE=4, DRAIN=2, WAKE=2, CNT_W=2) for timing, abort, async reset and saturation.
module tb_clk_enable_ctrl;

  localparam logic [1:0] S_ON = 2'd0, S_DRAIN = 2'd1, S_OFF = 2'd2, S_WAKE = 2'd3;

  logic       clk = 1'b0;
  logic       rst_a, activity_a, force_on_a;
  logic       clken_a, ready_a;
  logic [1:0] state_a;
  logic [7:0] sleep_cnt_a;

  logic       rst_b, activity_b, force_on_b;
  logic       clken_b, ready_b;
  logic [1:0] state_b;
  logic [1:0] sleep_cnt_b;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  clk_enable_ctrl u_def (
    .clk(clk), .rst(rst_a), .activity(activity_a), .force_on(force_on_a),
    .clken(clken_a), .ready(ready_a), .state(state_a), .sleep_cnt(sleep_cnt_a)
  );

  clk_enable_ctrl #(.IDLE_CYCLES(4), .DRAIN_CYCLES(2), .WAKE_CYCLES(2), .CNT_W(2)) u_dut (
    .clk(clk), .rst(rst_b), .activity(activity_b), .force_on(force_on_b),
    .clken(clken_b), .ready(ready_b), .state(state_b), .sleep_cnt(sleep_cnt_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic [1:0] st, input logic ck, input logic rd);
    check({tag, ".state"}, int'(state_b), int'(st));
    check({tag, ".clken"}, int'(clken_b), int'(ck));
    check({tag, ".ready"}, int'(ready_b), int'(rd));
  endtask

  initial begin
    rst_a = 1'b1; activity_a = 1'b0; force_on_a = 1'b1;
    rst_b = 1'b1; activity_b = 1'b0; force_on_b = 1'b0;
    #2;
    check("rst_a.state", int'(state_a), 0);
    check("rst_a.sleep", int'(sleep_cnt_a), 0);
    chk_b("rst_b", S_ON, 1'b1, 1'b1);
    check("rst_b.sleep", int'(sleep_cnt_b), 0);

    // force_on holds the default instance in ON
    tick();
    rst_a = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      check("force_on.hold", {state_a, clken_a, ready_a, sleep_cnt_a}, {2'd0, 1'b1, 1'b1, 8'd0});
    end
    $display("force_on hold: 200 cycles checked");

    // idle countdown: ready drops after edge 4, clken after edge 6
    rst_b = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_b("idle.on", S_ON, 1'b1, 1'b1);
    end
    tick(); chk_b("idle.e4", S_DRAIN, 1'b1, 1'b0);
    tick(); chk_b("idle.e5", S_DRAIN, 1'b1, 1'b0);
    tick(); chk_b("idle.e6", S_OFF, 1'b0, 1'b0);
    check("idle.sleep", int'(sleep_cnt_b), 1);
    tick(); chk_b("off.hold", S_OFF, 1'b0, 1'b0);
    $display("idle to OFF: sleep_cnt=%0d", sleep_cnt_b);

    // wake from OFF on a one-cycle pulse
    activity_b = 1'b1;
    tick(); chk_b("wake.t", S_WAKE, 1'b1, 1'b0);
    activity_b = 1'b0;
    tick(); chk_b("wake.t1", S_WAKE, 1'b1, 1'b0);
    tick(); chk_b("wake.t2", S_ON, 1'b1, 1'b1);
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_b("wake.fresh", S_ON, 1'b1, 1'b1);
    end
    tick(); chk_b("wake.drain", S_DRAIN, 1'b1, 1'b0);
    $display("wake from OFF: ready after t+2, new idle countdown done");

    // abort in first DRAIN cycle
    activity_b = 1'b1;
    tick(); chk_b("abort", S_ON, 1'b1, 1'b1);
    check("abort.sleep", int'(sleep_cnt_b), 1);
    activity_b = 1'b0;
    $display("drain abort: state=%0d", state_b);

    // activity exactly on the 4th idle edge beats the timeout
    for (int e = 1; e <= 3; e++) tick();
    activity_b = 1'b1;
    tick(); chk_b("edge4.wake", S_ON, 1'b1, 1'b1);
    activity_b = 1'b0;
    for (int e = 1; e <= 3; e++) begin
      tick();
      chk_b("edge4.recount", S_ON, 1'b1, 1'b1);
    end
    tick(); chk_b("edge4.drain", S_DRAIN, 1'b1, 1'b0);
    tick(); tick(); chk_b("edge4.off", S_OFF, 1'b0, 1'b0);
    check("edge4.sleep", int'(sleep_cnt_b), 2);
    $display("wake on timeout edge: counter restarted");

    // async reset mid-OFF, between edges
    rst_b = 1'b1;
    #1;
    chk_b("arst.off", S_ON, 1'b1, 1'b1);
    check("arst.off.sleep", int'(sleep_cnt_b), 0);
    #1 rst_b = 1'b0;

    // async reset mid-WAKE
    for (int e = 1; e <= 6; e++) tick();
    check("arst.pre_off", int'(state_b), int'(S_OFF));
    activity_b = 1'b1;
    tick(); chk_b("arst.pre_wake", S_WAKE, 1'b1, 1'b0);
    activity_b = 1'b0;
    rst_b = 1'b1;
    #1;
    chk_b("arst.wake", S_ON, 1'b1, 1'b1);
    check("arst.wake.sleep", int'(sleep_cnt_b), 0);
    #1 rst_b = 1'b0;
    $display("async reset in OFF and WAKE: outputs restored before next edge");

    // five sleep/wake rounds saturate a 2-bit sleep_cnt at 3
    for (int r = 0; r < 5; r++) begin
      for (int e = 1; e <= 6; e++) tick();
      check("sat.off", int'(state_b), int'(S_OFF));
      check("sat.cnt", int'(sleep_cnt_b), (r + 1 > 3) ? 3 : r + 1);
      $display("sleep round %0d: sleep_cnt=%0d", r + 1, sleep_cnt_b);
      activity_b = 1'b1;
      tick();
      activity_b = 1'b0;
      tick(); tick();
      check("sat.on", int'(state_b), int'(S_ON));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
